spi_xfer_ctrl: RTL and testbench
================================

Name: spi_xfer_ctrl

Overview:
Transaction controller sitting directly upstream of the team's SPI master.
- Accepts TX words over a valid/ready stream.
- Manages an active-low chip select with programmable setup, hold and inter-frame gap.
- Issues start pulses to the master and waits for its done tick.
- Returns each received word over a valid/ready stream.
- Supports multi-word bursts with chip select held low between words.

Parameters:
WordLength, 24, SPI word width; must match the downstream master.
CntWidth, 8, width of the setup/hold/gap delay inputs and their counter.
TimeoutCycles, 65535, done-tick watchdog limit; used only with the optional feature.

Ports:
clk_i  in  1  clock; all logic on the rising edge.
rst_ni  in  1  synchronous reset, active-low.
tx_data_i  in  WordLength  word to transmit.
tx_last_i  in  1  word ends the frame; chip select released after it.
tx_valid_i  in  1  TX word valid.
tx_ready_o  out  1  controller can accept a TX word.
rx_data_o  out  WordLength  received word.
rx_valid_o  out  1  RX word valid.
rx_ready_i  in  1  RX consumer ready.
cs_setup_i  in  CntWidth  CS-low to first start delay, minus one, in clk cycles.
cs_hold_i  in  CntWidth  last done to CS-high delay, minus one.
cs_gap_i  in  CntWidth  minimum CS-high time before the next frame, minus one.
ss_n_o  out  1  chip select, active-low, registered.
busy_o  out  1  high in every state except IDLE.
err_timeout_o  out  1  one-cycle watchdog pulse.
spi_din_o  out  WordLength  data to master; holds the latched TX word.
spi_start_o  out  1  one-cycle start pulse to master.
spi_ready_i  in  1  master idle.
spi_done_tick_i  in  1  master word-complete tick.
spi_dout_i  in  WordLength  master received data; valid when spi_done_tick_i is high.

Behaviour:
- Reset (rst_ni low at a clock edge):
  - state=IDLE, ss_n_o=1, spi_start_o=0, rx_valid_o=0, busy_o=0, err_timeout_o=0.
  - rx_data_o=0, spi_din_o=0, counter=0.
  - tx_ready_o=0 while rst_ni is low.
  - Reset mid-frame aborts the frame: CS goes high at the reset edge and no RX word is produced.
- Delay counting: a delay of value D occupies exactly D+1 cycles; the counter is cleared on every state entry.
- IDLE:
  - tx_ready_o=1.
  - On the accept cycle (tx_valid_i && tx_ready_o): latch tx_data_i into spi_din_o, latch tx_last_i, drive ss_n_o low next cycle, go to SETUP.
- SETUP: count cs_setup_i, then go to ISSUE.
- ISSUE:
  - spi_start_o=1 (combinational) when spi_ready_i=1, then go to BUSY.
  - If spi_ready_i=0, stay in ISSUE with start low.
- BUSY:
  - On spi_done_tick_i: capture spi_dout_i into rx_data_o, set rx_valid_o, go to RESP.
  - A done tick arriving in any other state is ignored.
- RESP:
  - rx_valid_o stays high until the cycle where rx_ready_i=1, then clears.
  - On that handshake cycle, go to HOLD if the latched last flag is set, else NEXT.
  - No RX data is ever overwritten or dropped.
- NEXT:
  - ss_n_o stays low; tx_ready_o=1.
  - On accept: latch data and last flag, go straight to ISSUE (no setup delay).
- HOLD: count cs_hold_i, drive ss_n_o high next cycle, go to GAP.
- GAP:
  - Count cs_gap_i, then go to IDLE.
  - tx_ready_o=0 throughout, so back-to-back frames are always separated by at least cs_gap_i+1 CS-high cycles.
- Simultaneous events: tx_valid_i outside IDLE/NEXT is not accepted, because tx_ready_o=0.
- Word-to-word latency inside a burst: done tick → RESP; rx handshake → NEXT; accept → ISSUE; start. That is 3 cycles minimum, with immediate rx_ready_i and tx_valid_i.

Optional Feature:
SPI_XFER_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in BUSY.
  - If TimeoutCycles cycles elapse without spi_done_tick_i: pulse err_timeout_o for one cycle, produce no RX word, go to HOLD (frame closed, CS released normally).
- Undefined: no watchdog logic; err_timeout_o is tied to 0; BUSY waits indefinitely.

Decomposition:
- Package spi_xfer_pkg: state enum type (IDLE, SETUP, ISSUE, BUSY, RESP, NEXT, HOLD, GAP) and the default TimeoutCycles constant.
- Sub-module spi_delay_cnt: a loadable CntWidth-bit down-counter with a done flag, reused by SETUP, HOLD and GAP.
- Everything else lives in a single FSM with its registers.

Test Plan:
1. Single word, setup=2, hold=1, gap=3, tx 0xA5A5A5 with last=1, model master echoes 0x123456 → ss_n low 3 cycles before spi_start_o; rx_data_o=0x123456; ss_n high 2 cycles after the RX handshake; tx_ready_o low for 4 cycles afterwards.
2. Three-word burst, last flag on word 3 → ss_n stays low across all 3 words; exactly 3 start pulses and 3 RX words; setup delay applied only before word 1.
3. RX backpressure: rx_ready_i held low for 10 cycles after done → rx_valid_o and rx_data_o held stable, tx_ready_o=0, no second start pulse issued.
4. spi_ready_i low for 5 cycles in ISSUE → spi_start_o stays 0 until spi_ready_i rises, then pulses exactly 1 cycle.
5. rst_ni asserted in BUSY → next cycle ss_n_o=1, busy_o=0, rx_valid_o=0; a late done tick produces no RX word.
6. With SPI_XFER_TIMEOUT_EN and TimeoutCycles=100, master never ticks → err_timeout_o pulses once at cycle 100 of BUSY; CS then released after hold; controller returns to IDLE.

Source files
------------

// File: rtl/spi_xfer_pkg.sv
// Shared types and constants for the SPI transaction controller.
package spi_xfer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StIssue,
    StBusy,
    StResp,
    StNext,
    StHold,
    StGap
  } state_e;

  localparam int unsigned TimeoutCyclesDefault = 65535;

endpackage

// File: rtl/spi_delay_cnt.sv
// Loadable down-counter; done_o is high once the count reaches zero.
module spi_delay_cnt import spi_xfer_pkg::*; #(
  parameter int unsigned CntWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic [CntWidth-1:0] load_val_i,
  output logic                done_o
);

  logic [CntWidth-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= load_val_i;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CntWidth'(1);
    end
  end

  assign done_o = (r_cnt == '0);

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI transaction controller: chip-select sequencing, start/done handshake and RX return.
// Optional done-tick watchdog enabled by defining SPI_XFER_TIMEOUT_EN.
module spi_xfer_ctrl import spi_xfer_pkg::*; #(
  parameter int unsigned WordLength    = 24,
  parameter int unsigned CntWidth      = 8,
  parameter int unsigned TimeoutCycles = TimeoutCyclesDefault
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [WordLength-1:0] tx_data_i,
  input  logic                  tx_last_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [WordLength-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  input  logic [CntWidth-1:0]   cs_setup_i,
  input  logic [CntWidth-1:0]   cs_hold_i,
  input  logic [CntWidth-1:0]   cs_gap_i,
  output logic                  ss_n_o,
  output logic                  busy_o,
  output logic                  err_timeout_o,
  output logic [WordLength-1:0] spi_din_o,
  output logic                  spi_start_o,
  input  logic                  spi_ready_i,
  input  logic                  spi_done_tick_i,
  input  logic [WordLength-1:0] spi_dout_i
);

  state_e                r_state, w_state_next;
  logic                  r_ss_n, r_last, r_rx_valid;
  logic [WordLength-1:0] r_din, r_rx_data;
  logic                  w_tx_ready, w_tx_accept, w_timeout;
  logic                  w_cnt_load, w_cnt_done;
  logic [CntWidth-1:0]   w_cnt_val;

  spi_delay_cnt #(
    .CntWidth(CntWidth)
  ) u_delay_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (w_cnt_load),
    .load_val_i(w_cnt_val),
    .done_o    (w_cnt_done)
  );

`ifdef SPI_XFER_TIMEOUT_EN
  localparam int unsigned WdogWidth = $clog2(TimeoutCycles + 1);
  logic [WdogWidth-1:0] r_wdog;

  // Restarts on every entry to BUSY; fires on the TimeoutCycles-th BUSY cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || r_state != StBusy) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + WdogWidth'(1);
    end
  end

  assign w_timeout = (r_state == StBusy) && !spi_done_tick_i &&
                     (r_wdog == WdogWidth'(TimeoutCycles - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |TimeoutCycles;
  assign w_timeout        = 1'b0;
`endif

  assign w_tx_accept = tx_valid_i && w_tx_ready;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_val    = '0;
    case (r_state)
      StIdle: begin
        if (w_tx_accept) begin
          w_state_next = StSetup;
          w_cnt_load   = 1'b1;
          w_cnt_val    = cs_setup_i;
        end
      end
      StSetup: if (w_cnt_done) w_state_next = StIssue;
      StIssue: if (spi_ready_i) w_state_next = StBusy;
      StBusy: begin
        if (spi_done_tick_i) begin
          w_state_next = StResp;
        end else if (w_timeout) begin
          w_state_next = StHold;
          w_cnt_load   = 1'b1;
          w_cnt_val    = cs_hold_i;
        end
      end
      StResp: begin
        if (rx_ready_i) begin
          if (r_last) begin
            w_state_next = StHold;
            w_cnt_load   = 1'b1;
            w_cnt_val    = cs_hold_i;
          end else begin
            w_state_next = StNext;
          end
        end
      end
      StNext: if (w_tx_accept) w_state_next = StIssue;
      StHold: begin
        if (w_cnt_done) begin
          w_state_next = StGap;
          w_cnt_load   = 1'b1;
          w_cnt_val    = cs_gap_i;
        end
      end
      StGap: if (w_cnt_done) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_tx_ready  = rst_ni && ((r_state == StIdle) || (r_state == StNext));
    spi_start_o = (r_state == StIssue) && spi_ready_i;
    busy_o      = (r_state != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ss_n     <= 1'b1;
      r_last     <= 1'b0;
      r_din      <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      if (w_tx_accept) begin
        r_din  <= tx_data_i;
        r_last <= tx_last_i;
      end
      if (r_state == StIdle && w_tx_accept) begin
        r_ss_n <= 1'b0;
      end else if (r_state == StHold && w_cnt_done) begin
        r_ss_n <= 1'b1;
      end
      if (r_state == StBusy && spi_done_tick_i) begin
        r_rx_data  <= spi_dout_i;
        r_rx_valid <= 1'b1;
      end else if (r_state == StResp && rx_ready_i) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign tx_ready_o    = w_tx_ready;
  assign rx_data_o     = r_rx_data;
  assign rx_valid_o    = r_rx_valid;
  assign ss_n_o        = r_ss_n;
  assign spi_din_o     = r_din;
  assign err_timeout_o = w_timeout;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed self-checking bench for spi_xfer_ctrl; drives on negedge, samples #1 later.
module tb_spi_xfer_ctrl;

  logic        clk_i, rst_ni;
  logic [23:0] tx_data_i, rx_data_o, spi_din_o, spi_dout_i;
  logic        tx_last_i, tx_valid_i, tx_ready_o, rx_valid_o, rx_ready_i;
  logic [7:0]  cs_setup_i, cs_hold_i, cs_gap_i;
  logic        ss_n_o, busy_o, err_timeout_o, spi_start_o, spi_ready_i, spi_done_tick_i;

  int n_cmp = 0;
  int n_bad = 0;

  spi_xfer_ctrl #(
    .WordLength   (24),
    .CntWidth     (8),
    .TimeoutCycles(100)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .tx_data_i      (tx_data_i),
    .tx_last_i      (tx_last_i),
    .tx_valid_i     (tx_valid_i),
    .tx_ready_o     (tx_ready_o),
    .rx_data_o      (rx_data_o),
    .rx_valid_o     (rx_valid_o),
    .rx_ready_i     (rx_ready_i),
    .cs_setup_i     (cs_setup_i),
    .cs_hold_i      (cs_hold_i),
    .cs_gap_i       (cs_gap_i),
    .ss_n_o         (ss_n_o),
    .busy_o         (busy_o),
    .err_timeout_o  (err_timeout_o),
    .spi_din_o      (spi_din_o),
    .spi_start_o    (spi_start_o),
    .spi_ready_i    (spi_ready_i),
    .spi_done_tick_i(spi_done_tick_i),
    .spi_dout_i     (spi_dout_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic test_reset();
    rst_ni = 1'b0; tx_data_i = '0; tx_last_i = 1'b0; tx_valid_i = 1'b1; rx_ready_i = 1'b0;
    cs_setup_i = '0; cs_hold_i = '0; cs_gap_i = '0; spi_ready_i = 1'b1;
    spi_done_tick_i = 1'b0; spi_dout_i = '0;
    repeat (3) @(negedge clk_i);
    #1;
    n_cmp++; if (tx_ready_o !== 1'b0) begin n_bad++; $display("FAIL rst_tx_ready got=%0b exp=0", tx_ready_o); end
    n_cmp++; if (ss_n_o !== 1'b1) begin n_bad++; $display("FAIL rst_ss_n got=%0b exp=1", ss_n_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%0b exp=0", busy_o); end
    n_cmp++; if (rx_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_rx_valid got=%0b exp=0", rx_valid_o); end
    n_cmp++; if (spi_start_o !== 1'b0) begin n_bad++; $display("FAIL rst_start got=%0b exp=0", spi_start_o); end
    n_cmp++; if (rx_data_o !== 24'h0) begin n_bad++; $display("FAIL rst_rx_data got=%0h exp=0", rx_data_o); end
    n_cmp++; if (spi_din_o !== 24'h0) begin n_bad++; $display("FAIL rst_din got=%0h exp=0", spi_din_o); end
    n_cmp++; if (err_timeout_o !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%0b exp=0", err_timeout_o); end
    @(negedge clk_i);
    tx_valid_i = 1'b0; rst_ni = 1'b1;
    #1;
    n_cmp++; if (tx_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready got=%0b exp=1", tx_ready_o); end
    n_cmp++; if (ss_n_o !== 1'b1) begin n_bad++; $display("FAIL rst_release_ss_n got=%0b exp=1", ss_n_o); end
  endtask

  task automatic test_single();
    int cnt;
    cs_setup_i = 8'd2; cs_hold_i = 8'd1; cs_gap_i = 8'd3; spi_ready_i = 1'b1;
    @(negedge clk_i);
    tx_data_i = 24'hA5A5A5; tx_last_i = 1'b1; tx_valid_i = 1'b1;
    #1;
    n_cmp++; if (tx_ready_o !== 1'b1) begin n_bad++; $display("FAIL single_tx_ready got=%0b exp=1", tx_ready_o); end
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (spi_start_o) break;
      if (!ss_n_o) cnt++;
      @(negedge clk_i);
    end
    n_cmp++; if (spi_start_o !== 1'b1) begin n_bad++; $display("FAIL single_start_seen got=%0b exp=1", spi_start_o); end
    n_cmp++; if (cnt !== 3) begin n_bad++; $display("FAIL single_setup_cycles got=%0d exp=3", cnt); end
    n_cmp++; if (spi_din_o !== 24'hA5A5A5) begin n_bad++; $display("FAIL single_din got=%0h exp=a5a5a5", spi_din_o); end
    @(negedge clk_i);
    spi_done_tick_i = 1'b1; spi_dout_i = 24'h123456;
    #1;
    n_cmp++; if (spi_start_o !== 1'b0) begin n_bad++; $display("FAIL single_start_width got=%0b exp=0", spi_start_o); end
    @(negedge clk_i);
    spi_done_tick_i = 1'b0; spi_dout_i = '0;
    #1;
    n_cmp++; if (rx_valid_o !== 1'b1) begin n_bad++; $display("FAIL single_rx_valid got=%0b exp=1", rx_valid_o); end
    n_cmp++; if (rx_data_o !== 24'h123456) begin n_bad++; $display("FAIL single_rx_data got=%0h exp=123456", rx_data_o); end
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    rx_ready_i = 1'b0;
    #1;
    n_cmp++; if (rx_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_rx_clear got=%0b exp=0", rx_valid_o); end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ss_n_o) break;
      cnt++;
      @(negedge clk_i);
    end
    n_cmp++; if (cnt !== 2) begin n_bad++; $display("FAIL single_hold_cycles got=%0d exp=2", cnt); end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (tx_ready_o) break;
      cnt++;
      @(negedge clk_i);
    end
    n_cmp++; if (cnt !== 4) begin n_bad++; $display("FAIL single_gap_cycles got=%0d exp=4", cnt); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy got=%0b exp=0", busy_o); end
  endtask

  task automatic test_burst();
    int cnt, starts, cs_high;
    logic [23:0] exp_rx;
    cs_setup_i = 8'd1; cs_hold_i = 8'd0; cs_gap_i = 8'd0; spi_ready_i = 1'b1;
    starts = 0; cs_high = 0;
    for (int w = 0; w < 3; w++) begin
      tx_data_i = 24'h000111 * (w + 1); tx_last_i = (w == 2); tx_valid_i = 1'b1;
      #1;
      n_cmp++; if (tx_ready_o !== 1'b1) begin n_bad++; $display("FAIL burst_tx_ready w=%0d got=%0b exp=1", w, tx_ready_o); end
      @(negedge clk_i);
      tx_valid_i = 1'b0;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
        #1;
        if (ss_n_o) cs_high = 1;
        if (spi_start_o) begin starts++; break; end
        cnt++;
        @(negedge clk_i);
      end
      n_cmp++; if (cnt !== ((w == 0) ? 2 : 0)) begin n_bad++; $display("FAIL burst_issue_delay w=%0d got=%0d exp=%0d", w, cnt, (w == 0) ? 2 : 0); end
      n_cmp++; if (spi_din_o !== 24'h000111 * (w + 1)) begin n_bad++; $display("FAIL burst_din w=%0d got=%0h", w, spi_din_o); end
      @(negedge clk_i);
      exp_rx = 24'hABC000 + 24'(w);
      spi_done_tick_i = 1'b1; spi_dout_i = exp_rx;
      @(negedge clk_i);
      spi_done_tick_i = 1'b0;
      #1;
      if (ss_n_o) cs_high = 1;
      n_cmp++; if (rx_data_o !== exp_rx || rx_valid_o !== 1'b1) begin n_bad++; $display("FAIL burst_rx w=%0d got=%0h/%0b exp=%0h/1", w, rx_data_o, rx_valid_o, exp_rx); end
      rx_ready_i = 1'b1;
      @(negedge clk_i);
      rx_ready_i = 1'b0;
      #1;
      if (w < 2 && ss_n_o) cs_high = 1;
    end
    n_cmp++; if (starts !== 3) begin n_bad++; $display("FAIL burst_starts got=%0d exp=3", starts); end
    n_cmp++; if (cs_high !== 0) begin n_bad++; $display("FAIL burst_cs_held got=%0d exp=0", cs_high); end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (tx_ready_o) break;
      cnt++;
      @(negedge clk_i);
    end
    n_cmp++; if (cnt !== 2) begin n_bad++; $display("FAIL burst_close_cycles got=%0d exp=2", cnt); end
    n_cmp++; if (ss_n_o !== 1'b1) begin n_bad++; $display("FAIL burst_cs_release got=%0b exp=1", ss_n_o); end
  endtask

  task automatic test_backpressure();
    int bad_cycles;
    cs_setup_i = 8'd0; cs_hold_i = 8'd0; cs_gap_i = 8'd0; spi_ready_i = 1'b1;
    tx_data_i = 24'h111111; tx_last_i = 1'b0; tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    @(negedge clk_i);
    #1;
    n_cmp++; if (spi_start_o !== 1'b1) begin n_bad++; $display("FAIL bp_start got=%0b exp=1", spi_start_o); end
    @(negedge clk_i);
    spi_done_tick_i = 1'b1; spi_dout_i = 24'h5A5A5A;
    @(negedge clk_i);
    spi_done_tick_i = 1'b0; spi_dout_i = 24'hFFFFFF;
    tx_data_i = 24'h222222; tx_last_i = 1'b1; tx_valid_i = 1'b1;
    bad_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (rx_valid_o !== 1'b1 || rx_data_o !== 24'h5A5A5A || tx_ready_o !== 1'b0 ||
          spi_start_o !== 1'b0) bad_cycles++;
      @(negedge clk_i);
    end
    n_cmp++; if (bad_cycles !== 0) begin n_bad++; $display("FAIL bp_hold_stable got=%0d bad cycles exp=0", bad_cycles); end
    n_cmp++; if (spi_din_o !== 24'h111111) begin n_bad++; $display("FAIL bp_no_accept got=%0h exp=111111", spi_din_o); end
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    rx_ready_i = 1'b0;
    #1;
    n_cmp++; if (tx_ready_o !== 1'b1 || ss_n_o !== 1'b0) begin n_bad++; $display("FAIL bp_next got=%0b/%0b exp=1/0", tx_ready_o, ss_n_o); end
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    #1;
    n_cmp++; if (spi_start_o !== 1'b1 || spi_din_o !== 24'h222222) begin n_bad++; $display("FAIL bp_second got=%0b/%0h exp=1/222222", spi_start_o, spi_din_o); end
    @(negedge clk_i);
    spi_done_tick_i = 1'b1; spi_dout_i = 24'h333333;
    @(negedge clk_i);
    spi_done_tick_i = 1'b0;
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    rx_ready_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (tx_ready_o) break;
      @(negedge clk_i);
    end
    n_cmp++; if (tx_ready_o !== 1'b1 || ss_n_o !== 1'b1) begin n_bad++; $display("FAIL bp_idle got=%0b/%0b exp=1/1", tx_ready_o, ss_n_o); end
  endtask

  task automatic test_issue_wait();
    int early;
    cs_setup_i = 8'd0; cs_hold_i = 8'd0; cs_gap_i = 8'd0; spi_ready_i = 1'b0;
    tx_data_i = 24'h0F0F0F; tx_last_i = 1'b1; tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    early = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (spi_start_o !== 1'b0) early++;
      @(negedge clk_i);
    end
    n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL iw_no_start got=%0d exp=0", early); end
    n_cmp++; if (busy_o !== 1'b1 || ss_n_o !== 1'b0) begin n_bad++; $display("FAIL iw_waiting got=%0b/%0b exp=1/0", busy_o, ss_n_o); end
    spi_ready_i = 1'b1;
    #1;
    n_cmp++; if (spi_start_o !== 1'b1) begin n_bad++; $display("FAIL iw_start got=%0b exp=1", spi_start_o); end
    @(negedge clk_i);
    #1;
    n_cmp++; if (spi_start_o !== 1'b0) begin n_bad++; $display("FAIL iw_pulse_width got=%0b exp=0", spi_start_o); end
    spi_done_tick_i = 1'b1; spi_dout_i = 24'h777777;
    @(negedge clk_i);
    spi_done_tick_i = 1'b0;
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    rx_ready_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (tx_ready_o) break;
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset_busy();
    int seen;
    cs_setup_i = 8'd0; spi_ready_i = 1'b1;
    tx_data_i = 24'h444444; tx_last_i = 1'b1; tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    n_cmp++; if (busy_o !== 1'b1 || ss_n_o !== 1'b0) begin n_bad++; $display("FAIL rb_in_busy got=%0b/%0b exp=1/0", busy_o, ss_n_o); end
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    spi_done_tick_i = 1'b1; spi_dout_i = 24'h999999;
    #1;
    n_cmp++; if (ss_n_o !== 1'b1 || busy_o !== 1'b0 || rx_valid_o !== 1'b0) begin n_bad++; $display("FAIL rb_after_reset got=%0b/%0b/%0b exp=1/0/0", ss_n_o, busy_o, rx_valid_o); end
    @(negedge clk_i);
    spi_done_tick_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (rx_valid_o !== 1'b0 || busy_o !== 1'b0) seen++;
      @(negedge clk_i);
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rb_late_tick got=%0d cycles with rx/busy exp=0", seen); end
  endtask

`ifdef SPI_XFER_TIMEOUT_EN
  task automatic test_timeout();
    int b, cnt, rx_seen;
    cs_setup_i = 8'd0; cs_hold_i = 8'd1; cs_gap_i = 8'd0; spi_ready_i = 1'b1;
    tx_data_i = 24'h666666; tx_last_i = 1'b1; tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    @(negedge clk_i);
    #1;
    n_cmp++; if (spi_start_o !== 1'b1) begin n_bad++; $display("FAIL to_start got=%0b exp=1", spi_start_o); end
    @(negedge clk_i);
    b = 1; rx_seen = 0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (rx_valid_o) rx_seen++;
      if (err_timeout_o) break;
      b++;
      @(negedge clk_i);
    end
    n_cmp++; if (b !== 100) begin n_bad++; $display("FAIL to_cycle got=%0d exp=100", b); end
    @(negedge clk_i);
    #1;
    n_cmp++; if (err_timeout_o !== 1'b0) begin n_bad++; $display("FAIL to_pulse_width got=%0b exp=0", err_timeout_o); end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (rx_valid_o) rx_seen++;
      if (ss_n_o) break;
      cnt++;
      @(negedge clk_i);
    end
    n_cmp++; if (cnt !== 2) begin n_bad++; $display("FAIL to_hold got=%0d exp=2", cnt); end
    for (int i = 0; i < 20; i++) begin
      #1;
      if (tx_ready_o) break;
      @(negedge clk_i);
    end
    n_cmp++; if (busy_o !== 1'b0 || rx_seen !== 0) begin n_bad++; $display("FAIL to_idle got=%0b/%0d exp=0/0", busy_o, rx_seen); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_issue_wait();
    test_reset_busy();
`ifdef SPI_XFER_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
